// File: rtl/parking_gate_arbiter.sv
// Shares one barrier gate between the entry and exit lanes, round-robin on contention,
// and keeps the lot occupancy count. Runs on the slow 5 Hz tick clock.
module parking_gate_arbiter #(
    parameter int CAPACITY   = 7,
    parameter int CNT_W      = 3,
    parameter int OPEN_TICKS = 25
) (
    input  logic             clk_5hz,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             pass,
    output logic             gate,
    output logic             grant_entry,
    output logic             grant_exit,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             deny,
    output logic             timeout
);

    localparam int               TW     = $clog2(OPEN_TICKS);
    localparam logic [TW-1:0]    T_LAST = TW'(OPEN_TICKS - 1);
    localparam logic [CNT_W-1:0] CAP    = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic            last_entry;
    logic            entry_ok;
    logic            exit_ok;
    logic            expired;
    logic            is_open;

    assign is_open     = (state == OPEN_IN) || (state == OPEN_OUT);
    assign gate        = is_open;
    assign grant_entry = (state == OPEN_IN);
    assign grant_exit  = (state == OPEN_OUT);
    assign full        = (count == CAP);
    assign empty       = (count == '0);

    always_comb begin
        state_nxt = state;
        entry_ok  = entry_req & ~full;
        exit_ok   = exit_req & ~empty;
        expired   = (timer == T_LAST);
        case (state)
            IDLE: begin
                // On contention the lane that did not get the previous grant wins
                if (entry_ok && exit_ok)
                    state_nxt = last_entry ? OPEN_OUT : OPEN_IN;
                else if (entry_ok)
                    state_nxt = OPEN_IN;
                else if (exit_ok)
                    state_nxt = OPEN_OUT;
            end
            OPEN_IN, OPEN_OUT: begin
                if (pass || expired)
                    state_nxt = CLOSE;
            end
            CLOSE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_5hz) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            count      <= '0;
            last_entry <= 1'b0;
            deny       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= is_open ? timer + TW'(1) : '0;
            deny    <= (state == IDLE) & entry_req & full;
            // A pass on the expiry edge takes priority, so no timeout then
            timeout <= is_open & ~pass & expired;

            if (state == IDLE && state_nxt == OPEN_IN)
                last_entry <= 1'b1;
            else if (state == IDLE && state_nxt == OPEN_OUT)
                last_entry <= 1'b0;

            if (state == OPEN_IN && pass && count != CAP)
                count <= count + CNT_W'(1);
            else if (state == OPEN_OUT && pass && count != '0)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed scenarios followed by random
// traffic, all compared against a lane/occupancy model kept in the bench.
module tb_parking_gate_arbiter;

    localparam int CAPACITY   = 3;
    localparam int CNT_W      = 2;
    localparam int OPEN_TICKS = 4;

    logic             clk_5hz = 1'b0;
    logic             reset = 1'b1;
    logic             entry_req = 1'b0;
    logic             exit_req = 1'b0;
    logic             pass = 1'b0;
    logic             gate;
    logic             grant_entry;
    logic             grant_exit;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             deny;
    logic             timeout;

    int total = 0;
    int bad = 0;

    // Model: who owns the gate (0 none, 1 entry lane, 2 exit lane), how many open
    // cycles have elapsed, whether the mandatory closed cycle is pending, and who got
    // the most recent grant.
    int m_count = 0;
    int m_owner = 0;
    int m_open = 0;
    int m_cooling = 0;
    int m_last_entry = 0;
    bit m_deny = 1'b0;
    bit m_timeout = 1'b0;

    parking_gate_arbiter #(
        .CAPACITY(CAPACITY),
        .CNT_W(CNT_W),
        .OPEN_TICKS(OPEN_TICKS)
    ) dut (
        .clk_5hz(clk_5hz),
        .reset(reset),
        .entry_req(entry_req),
        .exit_req(exit_req),
        .pass(pass),
        .gate(gate),
        .grant_entry(grant_entry),
        .grant_exit(grant_exit),
        .count(count),
        .full(full),
        .empty(empty),
        .deny(deny),
        .timeout(timeout)
    );

    always #5 clk_5hz = ~clk_5hz;

    task automatic modelStep(input bit r, input bit e, input bit x, input bit p);
        bit eok;
        bit xok;
        if (r) begin
            m_count = 0; m_owner = 0; m_open = 0; m_cooling = 0;
            m_last_entry = 0; m_deny = 0; m_timeout = 0;
        end else begin
            m_deny    = (m_owner == 0) && (m_cooling == 0) && e && (m_count == CAPACITY);
            m_timeout = 0;
            if (m_owner != 0) begin
                m_open = m_open + 1;
                if (p) begin
                    m_count   = (m_owner == 1) ? m_count + 1 : m_count - 1;
                    m_owner   = 0;
                    m_cooling = 1;
                end else if (m_open == OPEN_TICKS) begin
                    m_timeout = 1;
                    m_owner   = 0;
                    m_cooling = 1;
                end
            end else if (m_cooling != 0) begin
                m_cooling = 0;
            end else begin
                eok = e && (m_count < CAPACITY);
                xok = x && (m_count > 0);
                if (eok && xok)  m_owner = (m_last_entry != 0) ? 2 : 1;
                else if (eok)    m_owner = 1;
                else if (xok)    m_owner = 2;
                if (m_owner != 0) begin
                    m_last_entry = (m_owner == 1) ? 1 : 0;
                    m_open = 0;
                end
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("gate",        32'(gate),        32'(m_owner != 0));
        checkVal("grant_entry", 32'(grant_entry), 32'(m_owner == 1));
        checkVal("grant_exit",  32'(grant_exit),  32'(m_owner == 2));
        checkVal("count",       32'(count),       32'(m_count));
        checkVal("full",        32'(full),        32'(m_count == CAPACITY));
        checkVal("empty",       32'(empty),       32'(m_count == 0));
        checkVal("deny",        32'(deny),        32'(m_deny));
        checkVal("timeout",     32'(timeout),     32'(m_timeout));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then check 1 unit later
    task automatic applyStimulus(input bit r, input bit e, input bit x, input bit p);
        reset     = r;
        entry_req = e;
        exit_req  = x;
        pass      = p;
        @(posedge clk_5hz);
        modelStep(r, e, x, p);
        #1;
        checkOutput();
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkVal("reset_empty", 32'(empty), 32'd1);

        // Entry with pass on the second open cycle, then immediate re-grant
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkVal("t1_count", 32'(count), 32'd1);
        checkVal("t1_regrant", 32'(grant_entry), 32'd1);

        // Fill the lot and keep asking
        repeat (12) applyStimulus(0, 1, 0, 1);
        checkVal("t2_full", 32'(full), 32'd1);
        checkVal("t2_deny", 32'(deny), 32'd1);
        checkVal("t2_gate", 32'(gate), 32'd0);

        // One exit frees a slot; entry is granted two cycles after the exit pass
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 1, 1);
        checkVal("t2_count_after_exit", 32'(count), 32'd2);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkVal("t2_entry_after_exit", 32'(grant_entry), 32'd1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0);

        // Both lanes held: grants alternate
        repeat (16) applyStimulus(0, 1, 1, 1);

        // Timeout: request dropped right after the grant does not close the gate
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        repeat (OPEN_TICKS) applyStimulus(0, 0, 0, 0);
        checkVal("t4_timeout", 32'(timeout), 32'd1);
        checkVal("t4_gate", 32'(gate), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkVal("t4_pulse_end", 32'(timeout), 32'd0);

        // Pass on the expiry edge wins
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        repeat (OPEN_TICKS - 1) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkVal("t5_count", 32'(count), 32'd1);
        checkVal("t5_no_timeout", 32'(timeout), 32'd0);

        // Reset in the middle of an exit grant
        applyStimulus(1, 0, 0, 0);
        repeat (5) applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        checkVal("t6_exit_grant", 32'(grant_exit), 32'd1);
        applyStimulus(1, 0, 1, 0);
        checkVal("t6_gate", 32'(gate), 32'd0);
        checkVal("t6_count", 32'(count), 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 1) != 0),
                          ($urandom_range(0, 9) < 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
